// File: rtl/light_chaser_decoder.sv
// light_chaser_decoder: receive-side monitor for a one-hot LED chaser bus.
// Samples light_in on every enabled clock and decodes the lit position. It
// detects each shift step, counts laps, measures the dwell between shifts,
// and raises sticky flags for illegal patterns, skipped steps and dwell
// violations.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   enable         qualifies sampling; when low, all state and outputs hold
//   light_in       WIDTH-bit light vector from the chaser
//   pos            decoded index of the lit LED (0 = LSB)
//   pos_valid      tracking a legal one-hot pattern
//   step           one-cycle pulse on each legal advance
//   lap_count      wraps seen (modulo 2^LAP_W), kept across resync
//   last_dwell     dwell of the most recently completed pattern
//   err_onehot     sticky: non-one-hot value seen while tracking
//   err_skip       sticky: illegal transition seen while tracking
//   err_dwell      sticky: completed dwell differed from EXP_DWELL
//   locked         in TRACK state
//   dir            (LIGHT_CHASER_DECODER_BIDIR_EN only) 0 = left, 1 = right
//
// Optional feature macro: LIGHT_CHASER_DECODER_BIDIR_EN accepts right shifts
// as legal steps and adds the dir output.
module light_chaser_decoder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_DWELL = 5,
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned LAP_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         light_in,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic                     step,
  output logic [LAP_W-1:0]         lap_count,
  output logic [DWELL_W-1:0]       last_dwell,
  output logic                     err_onehot,
  output logic                     err_skip,
  output logic                     err_dwell,
  output logic                     locked
`ifdef LIGHT_CHASER_DECODER_BIDIR_EN
  ,
  output logic                     dir
`endif
);

  localparam int unsigned POS_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] SECOND_ONE = WIDTH'(2);
`ifdef LIGHT_CHASER_DECODER_BIDIR_EN
  localparam logic [WIDTH-1:0] MSB_ONE = LSB_ONE << (WIDTH - 1);
`endif

  typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

  state_t             state;
  logic [WIDTH-1:0]   prev;
  logic [DWELL_W-1:0] dwell;

  logic               onehot_c;
  logic               changed_c;
  logic               fwd_c;
  logic               rev_c;
  logic               wrap_c;
  logic [POS_W-1:0]   enc_c;
  logic [DWELL_W-1:0] dwell_inc_c;

  // Pattern classification against the previous enabled sample
  always_comb begin
    onehot_c    = (light_in != '0) && ((light_in & (light_in - WIDTH'(1))) == '0);
    changed_c   = (light_in != prev);
    // prev is one-hot in TRACK, so a rotate gives the shift-with-wrap successor
    fwd_c       = (light_in == {prev[WIDTH-2:0], prev[WIDTH-1]});
`ifdef LIGHT_CHASER_DECODER_BIDIR_EN
    rev_c       = (light_in == {prev[0], prev[WIDTH-1:1]});
`else
    rev_c       = 1'b0;
`endif
    // A lap is a left step landing on the LSB or a right step landing on the MSB
    wrap_c      = (fwd_c && light_in[0]) || (!fwd_c && rev_c && light_in[WIDTH-1]);
    dwell_inc_c = (dwell == '1) ? dwell : dwell + DWELL_W'(1);
    enc_c       = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (light_in[i]) enc_c = POS_W'(i);
    end
  end

  // Tracking FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      dwell      <= '0;
      pos        <= '0;
      pos_valid  <= 1'b0;
      step       <= 1'b0;
      lap_count  <= '0;
      last_dwell <= '0;
      err_onehot <= 1'b0;
      err_skip   <= 1'b0;
      err_dwell  <= 1'b0;
      locked     <= 1'b0;
`ifdef LIGHT_CHASER_DECODER_BIDIR_EN
      dir        <= 1'b0;
`endif
    end else begin
      step <= 1'b0;
      if (enable) begin
        prev <= light_in;
        case (state)
          IDLE: begin
            if (light_in == LSB_ONE) begin
              state <= SYNC;
              dwell <= DWELL_W'(1);
            end
          end
          SYNC: begin
            if (!changed_c) begin
              dwell <= dwell_inc_c;
            end else if (light_in == SECOND_ONE) begin
              // First dwell is partial: not reported or checked
              state     <= TRACK;
              step      <= 1'b1;
              pos       <= POS_W'(1);
              dwell     <= DWELL_W'(1);
              locked    <= 1'b1;
              pos_valid <= 1'b1;
`ifdef LIGHT_CHASER_DECODER_BIDIR_EN
              dir       <= 1'b0;
            end else if (light_in == MSB_ONE) begin
              state     <= TRACK;
              step      <= 1'b1;
              pos       <= POS_W'(WIDTH - 1);
              dwell     <= DWELL_W'(1);
              locked    <= 1'b1;
              pos_valid <= 1'b1;
              dir       <= 1'b1;
`endif
            end else begin
              state <= IDLE;
            end
          end
          TRACK: begin
            if (!changed_c) begin
              dwell <= dwell_inc_c;
            end else if (!onehot_c) begin
              err_onehot <= 1'b1;
              state      <= IDLE;
              locked     <= 1'b0;
              pos_valid  <= 1'b0;
            end else if (fwd_c || rev_c) begin
              step       <= 1'b1;
              pos        <= enc_c;
              last_dwell <= dwell;
              dwell      <= DWELL_W'(1);
              if (dwell != DWELL_W'(EXP_DWELL)) err_dwell <= 1'b1;
              if (wrap_c) lap_count <= lap_count + LAP_W'(1);
`ifdef LIGHT_CHASER_DECODER_BIDIR_EN
              dir        <= !fwd_c;
`endif
            end else begin
              err_skip  <= 1'b1;
              state     <= IDLE;
              locked    <= 1'b0;
              pos_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/light_chaser_decoder.md
Name: light_chaser_decoder

Overview:
- Receive-side monitor for the 8-bit LED chaser bus, sitting at the far end of the light output, for example on a board-level loopback or in a checker tile.
- Samples the light vector every clock and decodes the one-hot pattern to a position index.
- Detects each shift step, counts laps, and measures dwell time between shifts.
- Flags illegal patterns, skipped or out-of-order steps, and dwell-time violations against the expected chaser cadence.

Parameters:
- WIDTH, 8: width of the light bus. Must be a power of 2, at least 2.
- EXP_DWELL, 5: expected number of enabled cycles each pattern is held. The chaser advances once per 5 enabled cycles.
- DWELL_W, 8: width of the dwell counter. Saturates at all-ones.
- LAP_W, 8: width of the lap counter. Wraps modulo 2^LAP_W.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  qualifies sampling. When low, the decoder holds all state and outputs, and the dwell counter does not advance.
- light_in  in  WIDTH  light vector from the chaser
- pos  out  log2(WIDTH)  decoded index of the lit LED (0 = LSB)
- pos_valid  out  1  high while in TRACK and light_in is a legal one-hot
- step  out  1  one-cycle pulse on each legal advance
- lap_count  out  LAP_W  count of MSB-to-LSB wraps since sync
- last_dwell  out  DWELL_W  dwell of the most recently completed pattern
- err_onehot  out  1  sticky: a non-one-hot value was seen in TRACK
- err_skip  out  1  sticky: an illegal transition was seen
- err_dwell  out  1  sticky: a completed dwell differed from EXP_DWELL
- locked  out  1  high in TRACK state

Behaviour:
- Reset (async): state=IDLE. All outputs are 0: pos=0, lap_count=0, last_dwell=0, all error flags=0, step=0. The internal dwell counter and the previous-sample register are cleared.
- Input is registered once internally (prev). A "change" means light_in != prev while enable=1.
- States:
  - IDLE: wait for light_in == 1 (LSB lit) with enable=1, then go to SYNC and set dwell=1.
  - SYNC: hold while unchanged (dwell increments).
    - Change to 2 (LSB<<1): go to TRACK, pulse step, set pos=1, set dwell=1.
    - Any other change: return to IDLE with no error flagged.
    - The first dwell is partial, so it is not checked.
  - TRACK:
    - Unchanged: dwell++, saturating at 2^DWELL_W-1.
    - Legal change: next = prev<<1, or 1 when prev is the MSB. On a legal change:
      - pulse step, update pos;
      - last_dwell <= dwell, and set err_dwell if dwell != EXP_DWELL;
      - dwell <= 1;
      - on MSB->LSB, lap_count++.
    - Change to a non-one-hot value (zero or multiple bits): set err_onehot, clear pos_valid, go to IDLE.
    - Change to a one-hot that is not the legal successor: set err_skip, go to IDLE.
- Error flags are sticky and cleared only by rst. lap_count and last_dwell are retained across resync.
- step is registered: it asserts on the cycle after the clock edge where the change is sampled. pos updates on the same cycle as step.
- enable low mid-dwell: the dwell count freezes and resumes when enable returns. This matches the chaser, which also stalls.
- A dwell counter at saturation compares as saturated; it still differs from EXP_DWELL, so err_dwell is set.
- A simultaneous legal change and err_dwell condition both take effect: the step pulse occurs and err_dwell is set.

Optional Feature:
- Macro: LIGHT_CHASER_DECODER_BIDIR_EN.
- Defined:
  - prev>>1 (or MSB when prev is the LSB) is also a legal transition in TRACK.
  - An extra output dir (1 bit) is present: 0 = left shift, 1 = right shift, updated with step.
  - lap_count increments on wrap in either direction.
  - SYNC also accepts a change to the MSB as the first step.
- Undefined: a right shift sets err_skip, and the dir port is absent.

Test Plan:
- Reset: drive rst=1 mid-run -> all outputs 0 immediately (async); locked=0 until light_in=0x01 is seen with enable=1.
- Nominal chaser: 0x01, then shift every 5 enabled cycles for 20 steps -> 20 step pulses, pos cycling 1..7,0,..., lap_count=2 after the 16th step, last_dwell=5, no error flags.
- Dwell violation: in TRACK, hold 0x04 for 7 cycles, then 0x08 -> step pulse, last_dwell=7, err_dwell=1, still locked.
- Skip: in TRACK, go 0x04 -> 0x10 -> err_skip=1, locked=0. Then resync with 0x01 -> 0x02 -> locked=1 and err_skip stays 1.
- Illegal pattern: in TRACK, go 0x08 -> 0x18 -> err_onehot=1, pos_valid=0, state IDLE.
- Enable stall: hold 0x02 for 2 cycles, drop enable for 10 cycles, 3 more enabled cycles, then 0x04 -> last_dwell=5, err_dwell=0. With BIDIR_EN: 0x04 -> 0x02 -> step pulse, dir=1, no err_skip.
